core_ctrl_fsm: RTL and testbench
================================

Name: core_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback, and drives the enables for the IR, PC, register file, ALU operand mux and data memory. It reads the opcode field produced by the instruction decoder and classifies R, I-ALU, LOAD, STORE and BRANCH. Memory handshakes are req/ready with a bounded-wait watchdog.

Parameters:
WAIT_MAX, 255, max cycles a req may stay unanswered before bus_error; counter width = $clog2(WAIT_MAX+1).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  opcode field from the decoder, valid from DECODE onward
imem_ready  input  1  instruction memory data valid
dmem_ready  input  1  data memory access complete
branch_taken  input  1  branch comparator result, sampled in EXECUTE
imem_req  output  1  instruction fetch request
ir_we  output  1  latch imem data into IR
pc_we  output  1  PC update enable
pc_src  output  1  0 = PC+4, 1 = branch target
alu_src_imm  output  1  ALU operand B: 0 = rs2, 1 = immediate
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (store)
reg_we  output  1  register file write enable
wb_sel  output  1  writeback source: 0 = ALU, 1 = memory
illegal_instr  output  1  sticky: unsupported opcode
bus_error  output  1  sticky: memory watchdog expired
state_o  output  3  current state encoding
instret  output  CNT_W  retired-instruction count

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, ERROR=7. State, class register, wait counter, sticky flags and instret are async-cleared by rst_n low.
- Reset values: state IDLE, instret 0, illegal_instr/bus_error 0. All control outputs are 0 while in IDLE.
- Control outputs are combinational from state, the latched class and the ready inputs.
- IDLE: unconditionally goes to FETCH on the next clk.
- FETCH: imem_req=1.
  - imem_ready=1: ir_we=1 in the same cycle, go to DECODE.
- DECODE: register class from opcode.
  - 0110011 -> R; 0010011 -> I; 0000011 -> LOAD; 0100011 -> STORE; 1100011 -> BRANCH; go to EXECUTE.
  - Any other opcode: set illegal_instr, go to ERROR.
- EXECUTE: alu_src_imm=1 for I/LOAD/STORE, else 0.
  - R/I: go to WB.
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_we=1, pc_src=branch_taken, instret+1, go to FETCH.
- MEM: dmem_req=1, dmem_we=1 for STORE. Wait for dmem_ready.
  - LOAD: go to WB.
  - STORE: pc_we=1, pc_src=0, instret+1 in the ready cycle, go to FETCH.
- WB: reg_we=1, wb_sel=1 for LOAD else 0, pc_we=1, pc_src=0, instret+1, go to FETCH.
- Latency with zero wait states:
  - BRANCH 3 cycles (F,D,E).
  - R/I/STORE 4 cycles.
  - LOAD 5 cycles.
- Req signals are held high every cycle until the corresponding ready. A ready seen outside FETCH/MEM is ignored.
- Watchdog:
  - Counter clears on entry to FETCH and to MEM, and increments each cycle the req is high without ready.
  - Counter == WAIT_MAX with no ready: set bus_error, go to ERROR.
  - Ready in the same cycle the counter reaches WAIT_MAX: ready wins, no error.
- ERROR: all control outputs 0, flags held, instret frozen. Exit only via rst_n.
- instret wraps modulo 2^CNT_W.
- Reset asserted mid-operation (any state) returns to IDLE immediately. No pc_we/reg_we/dmem_req is issued while rst_n is low.

Test Plan:
- Reset release, imem_ready=1, opcode=0110011 -> state_o 0,1,2,3,5,1. reg_we=1, wb_sel=0, pc_we=1 in WB. instret=1 after 5 cycles from release.
- LOAD (0000011), dmem_ready low 3 cycles -> dmem_req high 4 cycles, dmem_we=0, alu_src_imm=1 in EXECUTE. WB has wb_sel=1, reg_we=1. instret +1.
- STORE (0100011), dmem_ready immediate -> dmem_req=dmem_we=1 for 1 cycle, pc_we=1 same cycle, reg_we never 1. Back in FETCH after 4 cycles.
- BRANCH (1100011), branch_taken=1 -> EXECUTE asserts pc_we=1, pc_src=1, no MEM/WB. Next state FETCH. Repeat with branch_taken=0 -> pc_src=0.
- opcode=1111111 -> illegal_instr=1, state_o=7, all enables 0 for 10+ cycles. rst_n pulse clears to IDLE, flags 0.
- WAIT_MAX=4, imem_ready held 0 -> bus_error on the 5th FETCH cycle, ERROR. Repeat with ready on that cycle -> DECODE, no error. Assert rst_n low during MEM -> dmem_req drops asynchronously, state_o=0.

Source files
------------

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/mem/writeback
// with req/ready memory handshakes guarded by a bounded-wait watchdog.
module core_ctrl_fsm #(
   parameter int WAIT_MAX = 255,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             branch_taken,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             alu_src_imm,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             illegal_instr,
   output logic             bus_error,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] instret
);

   localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERROR  = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_R, C_I, C_LOAD, C_STORE, C_BRANCH
   } cls_t;

   state_t            state, state_nxt;
   cls_t              cls, cls_nxt;
   logic [WW-1:0]     cnt, cnt_nxt;
   logic              set_ill, set_bus, retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cls           <= C_R;
         cnt           <= '0;
         illegal_instr <= 1'b0;
         bus_error     <= 1'b0;
         instret       <= '0;
      end else begin
         state <= state_nxt;
         cls   <= cls_nxt;
         cnt   <= cnt_nxt;
         if (set_ill) illegal_instr <= 1'b1;
         if (set_bus) bus_error <= 1'b1;
         if (retire)  instret <= instret + CNT_W'(1);
      end
   end

   // Counter is zeroed on every transition so it starts clean in FETCH/MEM
   always_comb begin
      state_nxt   = state;
      cls_nxt     = cls;
      cnt_nxt     = '0;
      set_ill     = 1'b0;
      set_bus     = 1'b0;
      retire      = 1'b0;
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 1'b0;
      alu_src_imm = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      reg_we      = 1'b0;
      wb_sel      = 1'b0;
      unique case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we     = 1'b1;
               state_nxt = S_DECODE;
            end else if (cnt == WMAX) begin
               set_bus   = 1'b1;
               state_nxt = S_ERROR;
            end else begin
               cnt_nxt = cnt + WW'(1);
            end
         end
         S_DECODE: begin
            state_nxt = S_EXEC;
            unique case (opcode)
               OP_R:      cls_nxt = C_R;
               OP_I:      cls_nxt = C_I;
               OP_LOAD:   cls_nxt = C_LOAD;
               OP_STORE:  cls_nxt = C_STORE;
               OP_BRANCH: cls_nxt = C_BRANCH;
               default: begin
                  set_ill   = 1'b1;
                  state_nxt = S_ERROR;
               end
            endcase
         end
         S_EXEC: begin
            alu_src_imm = (cls == C_I) || (cls == C_LOAD) ||
                          (cls == C_STORE);
            if (cls == C_BRANCH) begin
               pc_we     = 1'b1;
               pc_src    = branch_taken;
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end else if (cls == C_LOAD || cls == C_STORE) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls == C_STORE);
            if (dmem_ready) begin
               if (cls == C_STORE) begin
                  pc_we     = 1'b1;
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (cnt == WMAX) begin
               set_bus   = 1'b1;
               state_nxt = S_ERROR;
            end else begin
               cnt_nxt = cnt + WW'(1);
            end
         end
         S_WB: begin
            reg_we    = 1'b1;
            wb_sel    = (cls == C_LOAD);
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_ERROR: begin
            state_nxt = S_ERROR;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Self-checking bench for core_ctrl_fsm: directed scenarios plus random
// instruction streams checked cycle-by-cycle against an expected trace.
module tb_core_ctrl_fsm;

   localparam int WM = 4;
   localparam int CW = 4;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_L  = 7'b0000011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_X  = 7'b1111111;

   localparam logic [8:0] IMREQ = 9'h100;
   localparam logic [8:0] IRWE  = 9'h080;
   localparam logic [8:0] PCWE  = 9'h040;
   localparam logic [8:0] PCSRC = 9'h020;
   localparam logic [8:0] ALUI  = 9'h010;
   localparam logic [8:0] DMREQ = 9'h008;
   localparam logic [8:0] DMWE  = 9'h004;
   localparam logic [8:0] REGWE = 9'h002;
   localparam logic [8:0] WBSEL = 9'h001;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [6:0]    opcode = '0;
   logic          imem_ready = 1'b0;
   logic          dmem_ready = 1'b0;
   logic          branch_taken = 1'b0;
   logic          imem_req, ir_we, pc_we, pc_src, alu_src_imm;
   logic          dmem_req, dmem_we, reg_we, wb_sel;
   logic          illegal_instr, bus_error;
   logic [2:0]    state_o;
   logic [CW-1:0] instret;

   int checks = 0;
   int errors = 0;

   core_ctrl_fsm #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .branch_taken(branch_taken), .imem_req(imem_req),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_src_imm(alu_src_imm), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .reg_we(reg_we), .wb_sel(wb_sel),
      .illegal_instr(illegal_instr), .bus_error(bus_error),
      .state_o(state_o), .instret(instret)
   );

   always #5 clk = ~clk;

   wire [8:0] ctl = {imem_req, ir_we, pc_we, pc_src, alu_src_imm,
                     dmem_req, dmem_we, reg_we, wb_sel};

   typedef struct {
      logic [6:0]    op;
      logic          imr, dmr, bt;
      logic [2:0]    st;
      logic [8:0]    ctl;
      logic          ill, bus;
      logic [CW-1:0] ret;
   } ent_t;

   ent_t tq[$];
   logic          m_ill, m_bus;
   logic [CW-1:0] m_ret;

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   function automatic logic [6:0] r7();
      return 7'($urandom);
   endfunction

   task automatic push(input logic [2:0] st, input logic [8:0] c,
                       input logic imr, input logic dmr,
                       input logic [6:0] op, input logic bt);
      ent_t e;
      e.op = op; e.imr = imr; e.dmr = dmr; e.bt = bt;
      e.st = st; e.ctl = c;
      e.ill = m_ill; e.bus = m_bus; e.ret = m_ret;
      tq.push_back(e);
   endtask

   task automatic push_err();
      for (int k = 0; k < 10; k++) push(3'd7, 9'h0, rb(), rb(), r7(), rb());
   endtask

   // Expected trace of one instruction; iw/dw = ready latency in cycles
   task automatic gen_instr(input logic [6:0] op, input int iw,
                            input int dw, input logic bt,
                            output bit dead);
      int kind;
      logic [8:0] m;
      dead = 0;
      case (op)
         OP_R: kind = 0;
         OP_I: kind = 1;
         OP_L: kind = 2;
         OP_S: kind = 3;
         OP_B: kind = 4;
         default: kind = 5;
      endcase
      for (int k = 0; k < iw && k <= WM; k++)
         push(3'd1, IMREQ, 1'b0, rb(), r7(), rb());
      if (iw > WM) begin
         m_bus = 1'b1; push_err(); dead = 1;
      end else begin
         push(3'd1, IMREQ | IRWE, 1'b1, rb(), r7(), rb());
         push(3'd2, 9'h0, rb(), rb(), op, rb());
         if (kind == 5) begin
            m_ill = 1'b1; push_err(); dead = 1;
         end else if (kind == 4) begin
            push(3'd3, PCWE | (bt ? PCSRC : 9'h0), rb(), rb(), op, bt);
            m_ret = m_ret + 1'b1;
         end else begin
            push(3'd3, (kind >= 1) ? ALUI : 9'h0, rb(), rb(), op, rb());
            if (kind >= 2) begin
               m = DMREQ | ((kind == 3) ? DMWE : 9'h0);
               for (int k = 0; k < dw && k <= WM; k++)
                  push(3'd4, m, rb(), 1'b0, op, rb());
               if (dw > WM) begin
                  m_bus = 1'b1; push_err(); dead = 1;
               end else if (kind == 3) begin
                  push(3'd4, m | PCWE, rb(), 1'b1, op, rb());
                  m_ret = m_ret + 1'b1;
               end else begin
                  push(3'd4, m, rb(), 1'b1, op, rb());
               end
            end
            if (!dead && kind != 3) begin
               push(3'd5, REGWE | PCWE | ((kind == 2) ? WBSEL : 9'h0),
                    rb(), rb(), op, rb());
               m_ret = m_ret + 1'b1;
            end
         end
      end
   endtask

   // Plays n trace entries (all if n<0); entered and left at posedge+1
   task automatic play(input int n, input string tag);
      int lim;
      ent_t e;
      lim = (n < 0) ? tq.size() : n;
      for (int i = 0; i < lim; i++) begin
         e = tq.pop_front();
         opcode = e.op; imem_ready = e.imr;
         dmem_ready = e.dmr; branch_taken = e.bt;
         @(negedge clk);
         checks++;
         if (state_o !== e.st) begin
            errors++;
            $display("FAIL %s state cyc%0d: got %0d want %0d",
                     tag, i, state_o, e.st);
         end
         checks++;
         if (ctl !== e.ctl) begin
            errors++;
            $display("FAIL %s ctl cyc%0d st%0d: got %h want %h",
                     tag, i, e.st, ctl, e.ctl);
         end
         checks++;
         if ({illegal_instr, bus_error} !== {e.ill, e.bus}) begin
            errors++;
            $display("FAIL %s flags cyc%0d: got %b%b want %b%b",
                     tag, i, illegal_instr, bus_error, e.ill, e.bus);
         end
         checks++;
         if (instret !== e.ret) begin
            errors++;
            $display("FAIL %s instret cyc%0d: got %0d want %0d",
                     tag, i, instret, e.ret);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_ill = 1'b0; m_bus = 1'b0; m_ret = '0;
      tq.delete();
      push(3'd0, 9'h0, rb(), rb(), r7(), rb());
   endtask

   task automatic test_reset();
      bit d;
      rst_n = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b1;
      #13;
      checks++;
      if ({state_o, ctl, illegal_instr, bus_error, instret} !== '0) begin
         errors++;
         $display("FAIL reset: state %0d ctl %h flags %b%b instret %0d want 0",
                  state_o, ctl, illegal_instr, bus_error, instret);
      end
      do_reset();
      gen_instr(OP_R, 0, 0, 1'b0, d);
      gen_instr(OP_R, 1, 0, 1'b0, d);
      play(-1, "rtype");
   endtask

   task automatic test_load_store();
      bit d;
      do_reset();
      gen_instr(OP_L, 1, 3, 1'b0, d);
      gen_instr(OP_S, 0, 0, 1'b0, d);
      gen_instr(OP_I, 2, 0, 1'b0, d);
      gen_instr(OP_S, 0, 2, 1'b0, d);
      gen_instr(OP_L, 0, 0, 1'b0, d);
      play(-1, "ldst");
   endtask

   task automatic test_branch();
      bit d;
      do_reset();
      gen_instr(OP_B, 0, 0, 1'b1, d);
      gen_instr(OP_B, 0, 0, 1'b0, d);
      gen_instr(OP_B, 2, 0, 1'b1, d);
      play(-1, "branch");
   endtask

   task automatic test_illegal();
      bit d;
      do_reset();
      gen_instr(OP_R, 0, 0, 1'b0, d);
      gen_instr(OP_X, 0, 0, 1'b0, d);
      play(-1, "illegal");
      do_reset();
      play(-1, "illegal_clr");
   endtask

   task automatic test_watchdog();
      bit d;
      do_reset();
      gen_instr(OP_R, WM + 1, 0, 1'b0, d);
      play(-1, "wd_fetch_err");
      do_reset();
      gen_instr(OP_R, WM, 0, 1'b0, d);
      gen_instr(OP_S, 0, WM, 1'b0, d);
      gen_instr(OP_L, 0, WM + 1, 1'b0, d);
      play(-1, "wd_mem");
   endtask

   task automatic test_async_reset();
      bit d;
      do_reset();
      gen_instr(OP_L, 0, 3, 1'b0, d);
      play(6, "arst_pre");
      imem_ready = 1'b0; dmem_ready = 1'b0;
      #1;
      checks++;
      if (dmem_req !== 1'b1 || state_o !== 3'd4) begin
         errors++;
         $display("FAIL arst_mem: dmem_req %b state %0d want 1 4",
                  dmem_req, state_o);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || state_o !== 3'd0 || ctl !== 9'h0) begin
         errors++;
         $display("FAIL arst_drop: dmem_req %b state %0d ctl %h want 0",
                  dmem_req, state_o, ctl);
      end
      dmem_ready = 1'b1; imem_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ctl !== 9'h0 || state_o !== 3'd0 || instret !== '0) begin
         errors++;
         $display("FAIL arst_hold: ctl %h state %0d instret %0d want 0",
                  ctl, state_o, instret);
      end
   endtask

   task automatic test_wrap();
      bit d;
      do_reset();
      for (int i = 0; i < 20; i++) gen_instr(OP_B, 0, 0, rb(), d);
      play(-1, "wrap");
   endtask

   task automatic test_random();
      bit d;
      int p, iw, dw;
      logic [6:0] op;
      logic [6:0] legal[5];
      legal = '{OP_R, OP_I, OP_L, OP_S, OP_B};
      for (int r = 0; r < 8; r++) begin
         do_reset();
         d = 0;
         for (int i = 0; i < 30 && !d; i++) begin
            p = $urandom_range(0, 99);
            op = (p < 2) ? OP_X : legal[$urandom_range(0, 4)];
            p = $urandom_range(0, 99);
            iw = (p < 3) ? WM + 1 : (p < 10) ? WM : $urandom_range(0, 2);
            p = $urandom_range(0, 99);
            dw = (p < 3) ? WM + 1 : (p < 10) ? WM : $urandom_range(0, 2);
            gen_instr(op, iw, dw, rb(), d);
         end
         play(-1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_load_store();
      test_branch();
      test_illegal();
      test_watchdog();
      test_async_reset();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
